// File: rtl/mult_block_host.sv
// Host-side batch controller for the block multiplier: feeds operand pairs, triggers the
// block read once the result memory is full, and re-emits the read burst as an indexed stream.
module mult_block_host #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int OPW      = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [OPW-1:0]            op_a,
    input  logic [OPW-1:0]            op_b,
    output logic                      EN_mult,
    output logic [OPW-1:0]            mult_input0,
    output logic [OPW-1:0]            mult_input1,
    input  logic                      RDY_mult,
    output logic                      EN_blockRead,
    input  logic                      VALID_memVal,
    input  logic [WIDTH-1:0]          memVal_data,
    output logic                      res_valid,
    output logic [WIDTH-1:0]          res_data,
    output logic [LOGDEPTH-1:0]       res_index,
    output logic [WIDTH+LOGDEPTH-1:0] checksum,
    output logic [LOGDEPTH:0]         fed_count,
    output logic [LOGDEPTH:0]         rd_count,
    output logic                      busy,
    output logic                      batch_done,
    output logic                      err_timeout
);
    localparam int DEPTH = 2 ** LOGDEPTH;
    localparam int TW    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [LOGDEPTH:0] FULL  = (LOGDEPTH + 1)'(DEPTH);
    localparam logic [LOGDEPTH:0] CNT1  = (LOGDEPTH + 1)'(1);
    localparam logic [TW-1:0]     TLIM  = TW'(TIMEOUT);
    localparam logic [TW-1:0]     TONE  = TW'(1);

    typedef enum logic [2:0] {IDLE, FEED, WAIT_FULL, DRAIN, DONE} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          in_feed;
    logic          accept;

    // Operand path is combinational so a pair moves in the same cycle the multiplier is ready.
    assign in_feed     = (state == FEED);
    assign op_ready    = in_feed & RDY_mult;
    assign accept      = op_ready & op_valid;
    assign EN_mult     = accept;
    assign mult_input0 = in_feed ? op_a : '0;
    assign mult_input1 = in_feed ? op_b : '0;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            fed_count    <= '0;
            rd_count     <= '0;
            checksum     <= '0;
            err_timeout  <= 1'b0;
            EN_blockRead <= 1'b0;
            batch_done   <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_index    <= '0;
        end else begin
            EN_blockRead <= 1'b0;
            batch_done   <= 1'b0;
            res_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (start) begin
                        state       <= FEED;
                        fed_count   <= '0;
                        rd_count    <= '0;
                        checksum    <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                FEED: begin
                    timer <= '0;
                    if (accept) begin
                        fed_count <= fed_count + CNT1;
                        if (fed_count + CNT1 == FULL)
                            state <= WAIT_FULL;
                    end else if (!RDY_mult && fed_count != '0) begin
                        // multiplier closed its write window early
                        state <= WAIT_FULL;
                    end
                end
                WAIT_FULL: begin
                    if (!RDY_mult) begin
                        EN_blockRead <= 1'b1;
                        timer        <= '0;
                        state        <= DRAIN;
                    end else if (timer == TLIM) begin
                        err_timeout <= 1'b1;
                        batch_done  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        timer <= timer + TONE;
                    end
                end
                DRAIN: begin
                    if (VALID_memVal) begin
                        res_valid <= 1'b1;
                        res_data  <= memVal_data;
                        res_index <= rd_count[LOGDEPTH-1:0];
                        rd_count  <= rd_count + CNT1;
                        checksum  <= checksum + {{LOGDEPTH{1'b0}}, memVal_data};
                        timer     <= '0;
                        if (rd_count + CNT1 == FULL) begin
                            batch_done <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (rd_count != '0) begin
                        batch_done <= 1'b1;
                        state      <= DONE;
                    end else if (timer == TLIM) begin
                        err_timeout <= 1'b1;
                        batch_done  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        timer <= timer + TONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_block_host.sv
// Scoreboard bench: a behavioural multiplier model stores products and replays them on
// block read; stimulus pushes expected results, an independent monitor pops and compares.
module tb_mult_block_host;
    localparam int LOGDEPTH = 6;
    localparam int WIDTH    = 32;
    localparam int OPW      = 16;

    logic clk = 1'b0;
    logic rst, start, op_valid, op_ready, EN_mult, RDY_mult, EN_blockRead, VALID_memVal;
    logic [OPW-1:0] op_a, op_b, mult_input0, mult_input1;
    logic [WIDTH-1:0] memVal_data, res_data;
    logic res_valid, busy, batch_done, err_timeout;
    logic [LOGDEPTH-1:0] res_index;
    logic [WIDTH+LOGDEPTH-1:0] checksum;
    logic [LOGDEPTH:0] fed_count, rd_count;

    always #5 clk = ~clk;

    mult_block_host dut (
        .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .EN_mult(EN_mult), .mult_input0(mult_input0),
        .mult_input1(mult_input1), .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data), .res_valid(res_valid),
        .res_data(res_data), .res_index(res_index), .checksum(checksum),
        .fed_count(fed_count), .rd_count(rd_count), .busy(busy), .batch_done(batch_done),
        .err_timeout(err_timeout)
    );

    logic any_out;
    assign any_out = |{op_ready, EN_mult, mult_input0, mult_input1, EN_blockRead, res_valid,
                       res_data, res_index, checksum, fed_count, rd_count, busy, batch_done,
                       err_timeout};

    typedef struct packed {
        logic [LOGDEPTH-1:0] idx;
        logic [WIDTH-1:0]    data;
    } res_t;

    res_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int exp_fed, exp_rd, exp_br, exp_done, done_cnt, br_cnt;
    logic [WIDTH+LOGDEPTH-1:0] exp_sum;
    logic exp_err, want_read, stall;
    int limit, read_limit, mem_cnt;
    logic [WIDTH-1:0] mem[$];

    assign RDY_mult = !stall && (mem_cnt < limit);

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Multiplier model: writes products in order, closes when limit reached, replays on block read.
    initial begin : mult_model
        int rd_left, rd_ptr;
        logic en_s, br_s, st_s;
        logic [OPW-1:0] a_s, b_s;
        rd_left = 0; rd_ptr = 0; mem_cnt = 0;
        VALID_memVal = 1'b0; memVal_data = '0;
        forever begin
            @(negedge clk);
            en_s = EN_mult; a_s = mult_input0; b_s = mult_input1;
            br_s = EN_blockRead; st_s = start && !busy;
            @(posedge clk); #1;
            if (rst) begin
                mem.delete(); rd_left = 0; rd_ptr = 0;
            end else begin
                if (st_s) mem.delete();
                if (en_s) mem.push_back(32'(a_s) * 32'(b_s));
                if (rd_left > 0) begin rd_ptr++; rd_left--; end
                if (br_s) begin
                    rd_left = (mem.size() < read_limit) ? mem.size() : read_limit;
                    rd_ptr = 0;
                end
            end
            mem_cnt = mem.size();
            VALID_memVal = (rd_left > 0);
            memVal_data = (rd_left > 0) ? mem[rd_ptr] : '0;
        end
    end

    initial begin : monitor
        res_t e;
        done_cnt = 0; br_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete(); br_cnt = 0;
            end else begin
                if (EN_mult) begin
                    chk("en_mult_rdy", RDY_mult && op_valid, 1);
                    chk("mult_operands", (mult_input0 == op_a) && (mult_input1 == op_b), 1);
                end
                if (EN_blockRead) br_cnt++;
                if (res_valid) begin
                    chk("res_expected_avail", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("res_index", res_index, e.idx);
                        chk("res_data", res_data, e.data);
                    end
                end
                if (batch_done) begin
                    done_cnt++;
                    chk("end_fed_count", fed_count, exp_fed);
                    chk("end_rd_count", rd_count, exp_rd);
                    chk("end_checksum", checksum, exp_sum);
                    chk("end_err_timeout", err_timeout, exp_err);
                    chk("end_blockread_pulses", br_cnt, exp_br);
                    chk("end_results_left", exp_q.size(), 0);
                    br_cnt = 0;
                end
            end
        end
    end

    task automatic begin_batch(input int lim, input int rlim, input bit rd, input bit err);
        limit = lim; read_limit = rlim; want_read = rd; exp_err = err;
        exp_br = rd ? 1 : 0; exp_fed = 0; exp_rd = 0; exp_sum = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit rnd);
        logic [OPW-1:0] ca, cb;
        res_t e;
        int acc, cyc;
        acc = 0; cyc = 0;
        ca = rnd ? OPW'($urandom) : '0;
        cb = rnd ? OPW'($urandom) : OPW'(3);
        while (acc < n && cyc < 3000) begin
            op_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            op_a = ca; op_b = cb;
            @(negedge clk);
            if (op_valid && op_ready) begin
                if (want_read && acc < read_limit) begin
                    e.idx = LOGDEPTH'(acc);
                    e.data = 32'(ca) * 32'(cb);
                    exp_q.push_back(e);
                    exp_sum = exp_sum + (WIDTH + LOGDEPTH)'(e.data);
                    exp_rd++;
                end
                exp_fed++; acc++;
                ca = rnd ? OPW'($urandom) : OPW'(acc);
                cb = rnd ? OPW'($urandom) : OPW'(3);
            end
            @(posedge clk); #1;
            cyc++;
        end
        op_valid = 1'b0;
        if (acc < n) chk("feed_accepted", acc, n);
    endtask

    task automatic wait_done(input int maxc);
        int c;
        c = 0;
        do begin @(negedge clk); c++; end while (!batch_done && c < maxc);
        if (!batch_done) chk("batch_done_seen", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_br(input int maxc);
        int c;
        c = 0;
        do begin @(negedge clk); c++; end while (!EN_blockRead && c < maxc);
        if (!EN_blockRead) chk("blockread_seen", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int c;
        rst = 1'b1; start = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
        stall = 1'b0; limit = 64; read_limit = 64; want_read = 1'b1; exp_err = 1'b0;
        exp_fed = 0; exp_rd = 0; exp_br = 0; exp_sum = '0; exp_done = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", any_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_not_busy", busy, 0);

        // full batch: a=i, b=3
        begin_batch(64, 64, 1, 0);
        feed(64, 0);
        wait_done(600); exp_done++;
        chk("full_fed_count", fed_count, 64);
        chk("full_rd_count", rd_count, 64);
        chk("full_checksum", checksum, 6048);
        chk("full_idle_after", busy, 0);

        // backpressure before the first pair
        begin_batch(6, 64, 1, 0);
        repeat (2) begin
            @(negedge clk); chk("bp_ready_high", op_ready, 1);
            @(posedge clk); #1;
        end
        stall = 1'b1; op_valid = 1'b1; op_a = 16'h1234; op_b = 16'h0002;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", op_ready, 0);
            chk("bp_stay_feed", fed_count, 0);
            chk("bp_busy", busy, 1);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        feed(6, 1);
        wait_done(600); exp_done++;

        // short read: 63 beats
        begin_batch(64, 63, 1, 0);
        feed(64, 1);
        wait_done(600); exp_done++;
        chk("short_rd_count", rd_count, 63);
        chk("short_err", err_timeout, 0);

        // timeout: multiplier never closes
        begin_batch(1000, 64, 0, 1);
        feed(64, 1);
        c = 0;
        while (c < 400) begin
            @(posedge clk); c++;
            @(negedge clk);
            if (batch_done) break;
        end
        chk("timeout_latency", c, 256);
        @(posedge clk); #1; exp_done++;
        chk("timeout_err_held", err_timeout, 1);

        // start while busy is ignored; new start clears flags and counters
        begin_batch(20, 64, 1, 0);
        chk("restart_err_clear", err_timeout, 0);
        chk("restart_fed_clear", fed_count, 0);
        chk("restart_rd_clear", rd_count, 0);
        chk("restart_sum_clear", checksum, 0);
        feed(20, 1);
        wait_br(50);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(600); exp_done++;
        chk("restart_idle_after", busy, 0);

        for (int r = 0; r < 3; r++) begin
            int lim;
            lim = $urandom_range(1, 64);
            begin_batch(lim, 64, 1, 0);
            feed(lim, 1);
            wait_done(600); exp_done++;
        end

        // reset in the middle of DRAIN
        begin_batch(10, 64, 1, 0);
        feed(10, 1);
        wait_br(50);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_outputs_zero", any_out, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset_hold_zero", any_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_idle", busy, 0);
        chk("midreset_no_done", batch_done, 0);
        @(posedge clk); #1;

        begin_batch(64, 64, 1, 0);
        feed(64, 1);
        wait_done(600); exp_done++;

        repeat (5) @(posedge clk);
        #1;
        chk("batch_done_count", done_cnt, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
